bla_poly_engine: RTL

//  Parametrised successor to the single-line BLA wrapper: an outline rasteriser.

---
 rtl/bla_poly_engine.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/bla_poly_engine.sv
//------------------------------------------------------------------------------
// Module  : bla_poly_engine
// Brief   : Bresenham outline rasteriser for polylines/polygons into a 1-bpp buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bla_poly_engine #(
    parameter int COORD_W  = 8,
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int MAX_VERT = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              closed,
    input  logic                              keep_buf,
    input  logic [$clog2(MAX_VERT+1)-1:0]     vert_count,
    input  logic [2*COORD_W*MAX_VERT-1:0]     coordinates,
    output logic [IMG_W*IMG_H-1:0]            line_buffer,
    output logic                              pix_valid,
    output logic [COORD_W-1:0]                pix_x,
    output logic [COORD_W-1:0]                pix_y,
    output logic                              busy,
    output logic                              done
);

    localparam int VC_W  = $clog2(MAX_VERT+1);
    localparam int ERR_W = COORD_W + 2;
    localparam int E2_W  = COORD_W + 3;
    localparam int PIX_W = $clog2(IMG_W*IMG_H);
    localparam logic [VC_W-1:0] c_max_vert = VC_W'(MAX_VERT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

    state_t                    r_state, w_next;
    logic [COORD_W-1:0]        r_vx [MAX_VERT];
    logic [COORD_W-1:0]        r_vy [MAX_VERT];
    logic [VC_W-1:0]           r_n, r_edge, r_last;
    logic [COORD_W-1:0]        r_x, r_y, r_x1, r_y1;
    logic signed [ERR_W-1:0]   r_dx, r_dy, r_err;
    logic                      r_sx, r_sy;

    logic [VC_W-1:0]           w_n, w_last, w_edge_nx, w_b_idx;
    logic [COORD_W-1:0]        w_x0, w_y0, w_x1, w_y1, w_adx, w_ady;
    logic signed [ERR_W-1:0]   w_dx, w_dy, w_err_nx;
    logic signed [E2_W-1:0]    w_e2;
    logic                      w_step_x, w_step_y, w_at_end, w_in_img;
    logic [PIX_W-1:0]          w_pix_idx;

    // Edge count: n=1 is one degenerate edge; closing edge only for n>=3.
    always_comb begin
        w_n = (vert_count > c_max_vert) ? c_max_vert : vert_count;
        if (w_n == VC_W'(1))
            w_last = '0;
        else if (closed && (w_n >= VC_W'(3)))
            w_last = w_n - VC_W'(1);
        else
            w_last = w_n - VC_W'(2);
    end

    assign w_edge_nx = r_edge + VC_W'(1);
    assign w_b_idx   = (w_edge_nx >= r_n) ? '0 : w_edge_nx;

    always_comb begin
        w_x0 = '0;
        w_y0 = '0;
        w_x1 = '0;
        w_y1 = '0;
        for (int k = 0; k < MAX_VERT; k++) begin
            if (r_edge == VC_W'(k)) begin
                w_x0 = r_vx[k];
                w_y0 = r_vy[k];
            end
            if (w_b_idx == VC_W'(k)) begin
                w_x1 = r_vx[k];
                w_y1 = r_vy[k];
            end
        end
    end

    assign w_adx = (w_x1 >= w_x0) ? (w_x1 - w_x0) : (w_x0 - w_x1);
    assign w_ady = (w_y1 >= w_y0) ? (w_y1 - w_y0) : (w_y0 - w_y1);
    assign w_dx  = $signed({2'b00, w_adx});
    assign w_dy  = -$signed({2'b00, w_ady});

    assign w_e2     = {r_err, 1'b0};
    assign w_step_x = w_e2 >= $signed({r_dy[ERR_W-1], r_dy});
    assign w_step_y = w_e2 <= $signed({r_dx[ERR_W-1], r_dx});
    assign w_err_nx = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);
    assign w_at_end = (r_x == r_x1) && (r_y == r_y1);

    assign w_in_img  = ({1'b0, r_x} < (COORD_W+1)'(IMG_W)) &&
                       ({1'b0, r_y} < (COORD_W+1)'(IMG_H));
    assign w_pix_idx = PIX_W'(r_y * IMG_W + r_x);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (w_n == '0) ? S_DONE : S_LOAD;
            S_LOAD: w_next = S_DRAW;
            S_DRAW: if (w_at_end) w_next = (r_edge == r_last) ? S_DONE : S_LOAD;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_VERT; k++) begin
                r_vx[k] <= '0;
                r_vy[k] <= '0;
            end
            r_n         <= '0;
            r_edge      <= '0;
            r_last      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_err       <= '0;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            line_buffer <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    for (int k = 0; k < MAX_VERT; k++) begin
                        r_vx[k] <= coordinates[2*COORD_W*k +: COORD_W];
                        r_vy[k] <= coordinates[2*COORD_W*k + COORD_W +: COORD_W];
                    end
                    r_n    <= w_n;
                    r_last <= w_last;
                    r_edge <= '0;
                    if (!keep_buf) line_buffer <= '0;
                end
                S_LOAD: begin
                    r_x   <= w_x0;
                    r_y   <= w_y0;
                    r_x1  <= w_x1;
                    r_y1  <= w_y1;
                    r_dx  <= w_dx;
                    r_dy  <= w_dy;
                    r_sx  <= (w_x1 >= w_x0);
                    r_sy  <= (w_y1 >= w_y0);
                    r_err <= w_dx + w_dy;
                end
                S_DRAW: begin
                    if (w_in_img) line_buffer[w_pix_idx] <= 1'b1;
                    if (w_at_end) begin
                        r_edge <= w_edge_nx;
                    end else begin
                        if (w_step_x) r_x <= r_sx ? (r_x + 1'b1) : (r_x - 1'b1);
                        if (w_step_y) r_y <= r_sy ? (r_y + 1'b1) : (r_y - 1'b1);
                        r_err <= w_err_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pix_valid = (r_state == S_DRAW);
    assign pix_x     = r_x;
    assign pix_y     = r_y;

endmodule

`default_nettype wire
